// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight destination writes, raises
// load-use stalls and branch flushes, and registers forwarding selects for EX.
module hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2,
  localparam int SEL_W    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_wr_en,
  input  logic              issue_is_load,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rs1_used,
  input  logic              issue_rs2_used,
  input  logic              br_taken,
  output logic              stall_o,
  output logic              flush_o,
  output logic [SEL_W-1:0]  fwd_sel_rs1,
  output logic [SEL_W-1:0]  fwd_sel_rs2,
  output logic [CNT_W-1:0]  inflight_cnt
);

  logic              slot_valid [DEPTH];
  logic [REG_AW-1:0] slot_rd    [DEPTH];
  logic              slot_wr    [DEPTH];
  logic              slot_ld    [DEPTH];

  logic [2:0]        flush_cnt;

  logic [REG_AW-1:0] src_reg  [2];
  logic              src_used [2];
  logic              prod_hit [2];
  int                prod_k   [2];
  logic              prod_ld  [2];
  logic              src_haz  [2];
  logic [SEL_W-1:0]  sel_next [2];

  logic              br_fire;
  logic              accept;
  logic [CNT_W-1:0]  valid_sum;

  always_comb begin
    src_reg[0]  = issue_rs1;
    src_reg[1]  = issue_rs2;
    src_used[0] = issue_rs1_used;
    src_used[1] = issue_rs2_used;
  end

  // Scan oldest to youngest so the last match left standing is the youngest producer.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      prod_hit[s] = 1'b0;
      prod_k[s]   = 0;
      prod_ld[s]  = 1'b0;
      src_haz[s]  = 1'b0;
      sel_next[s] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_valid[k] && slot_wr[k] && (slot_rd[k] == src_reg[s]) && (src_reg[s] != '0)) begin
          prod_hit[s] = 1'b1;
          prod_k[s]   = k;
          prod_ld[s]  = slot_ld[k];
        end
      end
      if (src_used[s] && prod_hit[s]) begin
        src_haz[s] = prod_ld[s] && (prod_k[s] < LOAD_LAT);
        if (prod_k[s] < DEPTH - 1)
          sel_next[s] = SEL_W'(prod_k[s] + 1);
      end
    end
  end

  always_comb begin
    br_fire = br_taken && slot_valid[0];
    flush_o = br_fire || (flush_cnt != 3'd0);
    stall_o = issue_valid && !flush_o && (src_haz[0] || src_haz[1]);
    accept  = issue_valid && !stall_o && !flush_o;
  end

  always_comb begin
    valid_sum = '0;
    for (int k = 0; k < DEPTH; k++)
      valid_sum = valid_sum + CNT_W'(slot_valid[k]);
    inflight_cnt = valid_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_valid[k] <= 1'b0;
        slot_rd[k]    <= '0;
        slot_wr[k]    <= 1'b0;
        slot_ld[k]    <= 1'b0;
      end
      fwd_sel_rs1 <= '0;
      fwd_sel_rs2 <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_rd[k]    <= slot_rd[k-1];
        slot_wr[k]    <= slot_wr[k-1];
        slot_ld[k]    <= slot_ld[k-1];
      end
      slot_valid[0] <= accept;
      slot_rd[0]    <= accept ? issue_rd : '0;
      slot_wr[0]    <= accept && issue_wr_en;
      slot_ld[0]    <= accept && issue_is_load;
      fwd_sel_rs1   <= accept ? sel_next[0] : '0;
      fwd_sel_rs2   <= accept ? sel_next[1] : '0;
    end
  end

  // The branch's own cycle counts as the first squashed issue, so reload with one less.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flush_cnt <= 3'd0;
    else if (br_fire)
      flush_cnt <= 3'(FLUSH_CYC - 1);
    else if (flush_cnt != 3'd0)
      flush_cnt <= flush_cnt - 3'd1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, reset-abort
// sequence, and randomized traffic against a queue-based reference model.
module tb_hazard_scoreboard;

  localparam int REG_AW    = 5;
  localparam int DEPTH     = 3;
  localparam int LOAD_LAT  = 1;
  localparam int FLUSH_CYC = 2;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_wr_en;
  logic              issue_is_load;
  logic [REG_AW-1:0] issue_rs1;
  logic [REG_AW-1:0] issue_rs2;
  logic              issue_rs1_used;
  logic              issue_rs2_used;
  logic              br_taken;
  logic              stall_o;
  logic              flush_o;
  logic [SEL_W-1:0]  fwd_sel_rs1;
  logic [SEL_W-1:0]  fwd_sel_rs2;
  logic [CNT_W-1:0]  inflight_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr_en(issue_wr_en),
    .issue_is_load(issue_is_load), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .br_taken(br_taken), .stall_o(stall_o), .flush_o(flush_o),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; bit wr; bit ld; int rs1; bit u1; int rs2; bit u2; bit br;
    int e_stall; int e_flush; int e_f1; int e_f2; int e_cnt;
  } vec_t;

  typedef struct {bit valid; int rd; bit wr; bit ld;} ent_t;

  vec_t vecs[18];
  ent_t pipe[$];
  int   m_flush_left;
  int   m_f1, m_f2;

  function automatic vec_t mk(bit v, int rd, bit wr, bit ld, int rs1, bit u1, int rs2, bit u2,
                              bit br, int es, int ef, int ef1, int ef2, int ec);
    vec_t r;
    r.v = v; r.rd = rd; r.wr = wr; r.ld = ld; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.br = br; r.e_stall = es; r.e_flush = ef; r.e_f1 = ef1; r.e_f2 = ef2; r.e_cnt = ec;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    issue_valid    = s.v;
    issue_rd       = REG_AW'(s.rd);
    issue_wr_en    = s.wr;
    issue_is_load  = s.ld;
    issue_rs1      = REG_AW'(s.rs1);
    issue_rs1_used = s.u1;
    issue_rs2      = REG_AW'(s.rs2);
    issue_rs2_used = s.u2;
    br_taken       = s.br;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: youngest producer is the lowest queue index holding a write of r.
  function automatic int find_prod(int r);
    if (r == 0) return -1;
    for (int i = 0; i < DEPTH; i++)
      if (pipe[i].valid && pipe[i].wr && pipe[i].rd == r) return i;
    return -1;
  endfunction

  function automatic int count_valid();
    int n = 0;
    foreach (pipe[i]) if (pipe[i].valid) n++;
    return n;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{0, 0, 0, 0});
    m_flush_left = 0;
    m_f1 = 0;
    m_f2 = 0;
  endtask

  initial begin
    vec_t s;
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(idle);

    //           v  rd wr ld rs1 u1 rs2 u2 br  st fl f1 f2 cnt
    vecs[0]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 6, 1, 0, 5, 1, 5, 1, 0,  0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 2);
    vecs[3]  = mk(1, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    vecs[4]  = mk(1, 8, 1, 0, 7, 1, 0, 1, 0,  1, 0, 0, 0, 2);
    vecs[5]  = mk(1, 8, 1, 0, 7, 1, 0, 1, 0,  0, 0, 0, 0, 1);
    vecs[6]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 2);
    vecs[7]  = mk(1, 9, 1, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 2);
    vecs[8]  = mk(1, 10, 1, 0, 8, 1, 9, 1, 0, 0, 0, 0, 0, 3);
    vecs[9]  = mk(1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 3);
    vecs[10] = mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    vecs[11] = mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    vecs[13] = mk(1, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 16, 1, 0, 14, 1, 0, 0, 1, 0, 1, 0, 0, 2);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    vecs[16] = mk(1, 15, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    #3;
    checkOutput("reset_stall", stall_o, 0);
    checkOutput("reset_flush", flush_o, 0);
    checkOutput("reset_f1", fwd_sel_rs1, 0);
    checkOutput("reset_f2", fwd_sel_rs2, 0);
    checkOutput("reset_cnt", inflight_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d_stall", i), stall_o, vecs[i].e_stall);
      checkOutput($sformatf("vec%0d_flush", i), flush_o, vecs[i].e_flush);
      checkOutput($sformatf("vec%0d_f1", i), fwd_sel_rs1, vecs[i].e_f1);
      checkOutput($sformatf("vec%0d_f2", i), fwd_sel_rs2, vecs[i].e_f2);
      checkOutput($sformatf("vec%0d_cnt", i), inflight_cnt, vecs[i].e_cnt);
      @(posedge clk);
    end

    // Reset asserted while the flush counter is still running.
    @(negedge clk);
    applyStimulus(mk(1, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    applyStimulus(mk(1, 21, 1, 0, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkOutput("rst_seq_stall", stall_o, 0);
    @(negedge clk);
    applyStimulus(mk(1, 23, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    #2;
    checkOutput("rst_seq_fwd", fwd_sel_rs1, 1);
    checkOutput("rst_seq_flush", flush_o, 1);
    @(negedge clk);
    applyStimulus(mk(1, 24, 1, 0, 21, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 checkOutput("rst_seq_flush_hold", flush_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_abort_flush", flush_o, 0);
    checkOutput("rst_abort_stall", stall_o, 0);
    checkOutput("rst_abort_cnt", inflight_cnt, 0);
    checkOutput("rst_abort_f1", fwd_sel_rs1, 0);
    checkOutput("rst_abort_f2", fwd_sel_rs2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(1, 22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("rst_release_cnt", inflight_cnt, 1);
    checkOutput("rst_release_flush", flush_o, 0);

    // Clean restart for the randomized phase.
    @(negedge clk);
    applyStimulus(idle);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      int p1, p2, m_stall, m_flush, accept;
      bit fire;
      if (cyc > 0) @(negedge clk);
      s.v   = ($urandom_range(0, 3) != 0);
      s.rd  = $urandom_range(0, 7);
      s.wr  = ($urandom_range(0, 4) != 0);
      s.ld  = ($urandom_range(0, 2) == 0);
      s.rs1 = $urandom_range(0, 7);
      s.u1  = ($urandom_range(0, 3) != 0);
      s.rs2 = $urandom_range(0, 7);
      s.u2  = ($urandom_range(0, 1) != 0);
      s.br  = ($urandom_range(0, 5) == 0);
      applyStimulus(s);

      p1 = s.u1 ? find_prod(s.rs1) : -1;
      p2 = s.u2 ? find_prod(s.rs2) : -1;
      fire    = s.br && pipe[0].valid;
      m_flush = (fire || m_flush_left > 0) ? 1 : 0;
      m_stall = (s.v && !m_flush &&
                 ((p1 >= 0 && pipe[p1].ld && p1 < LOAD_LAT) ||
                  (p2 >= 0 && pipe[p2].ld && p2 < LOAD_LAT))) ? 1 : 0;
      accept  = (s.v && !m_stall && !m_flush) ? 1 : 0;

      #2;
      checkOutput("rand_stall", stall_o, m_stall);
      checkOutput("rand_flush", flush_o, m_flush);
      checkOutput("rand_f1", fwd_sel_rs1, m_f1);
      checkOutput("rand_f2", fwd_sel_rs2, m_f2);
      checkOutput("rand_cnt", inflight_cnt, count_valid());

      if (fire) m_flush_left = FLUSH_CYC - 1;
      else if (m_flush_left > 0) m_flush_left--;
      m_f1 = (accept && p1 >= 0 && p1 < DEPTH - 1) ? p1 + 1 : 0;
      m_f2 = (accept && p2 >= 0 && p2 < DEPTH - 1) ? p2 + 1 : 0;
      void'(pipe.pop_back());
      if (accept != 0) pipe.push_front('{1, s.rd, s.wr, s.ld});
      else             pipe.push_front('{0, 0, 0, 0});
      @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages (slot0=EX, slot1=MEM, slot2=WB); legal range 2..8.
REQ-003 SHALL have parameter LOAD_LAT, default 1, number of slots after EX before load data is forwardable; legal range 0..DEPTH-2.
REQ-004 SHALL have parameter FLUSH_CYC, default 2, issue cycles squashed per taken branch; legal range 1..7.
REQ-005 SHALL have derived width SEL_W = max(1, clog2(DEPTH)) and CNT_W = clog2(DEPTH+1).
REQ-006 SHALL have these ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  an instruction in ID requests entry to EX.
- issue_rd  in  REG_AW  destination register.
- issue_wr_en  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load.
- issue_rs1 / issue_rs2  in  REG_AW  source registers.
- issue_rs1_used / issue_rs2_used  in  1  source is actually read.
- br_taken  in  1  instruction in slot0 (EX) resolved a taken branch or jump.
- stall_o  out  1  hold IF/ID and insert a bubble into EX; combinational.
- flush_o  out  1  squash the current issue; combinational.
- fwd_sel_rs1 / fwd_sel_rs2  out  SEL_W  registered forwarding selects for the instruction in EX: 0 = register file; m = result of slot m.
- inflight_cnt  out  CNT_W  number of valid slots.

Function
REQ-007 SHALL hold per slot: valid, rd, wr, is_load.
REQ-008 SHALL treat a slot as a producer for register r only if valid, wr=1, rd=r, and r!=0.
REQ-009 SHALL shift every cycle: slot k+1 <= slot k for k=0..DEPTH-2; slot DEPTH-1 retires.
REQ-010 SHALL load slot0 with the issue fields only when issue_valid=1, stall_o=0 and flush_o=0; otherwise slot0 <= bubble (valid=0).
REQ-011 SHALL, for each used source, find the youngest producer (lowest slot index k) among the current slots.
REQ-012 SHALL register fwd_sel = k+1 on the accepting edge when k+1 <= DEPTH-1; fwd_sel = 0 when k = DEPTH-1 or there is no producer. The register file is write-first.
REQ-013 SHALL assert stall_o when issue_valid=1, flush_o=0, and any used source's youngest producer is a load at slot k < LOAD_LAT.
REQ-014 SHALL re-evaluate a stalled instruction each cycle it is presented; stall lasts exactly LOAD_LAT-k cycles.
REQ-015 SHALL assert flush_o when br_taken=1 and slot0.valid=1; a 3-bit counter then keeps flush_o high for the next FLUSH_CYC-1 cycles.
REQ-016 SHALL ignore br_taken while slot0.valid=0.
REQ-017 SHALL give flush priority over stall: stall_o=0 whenever flush_o=1.
REQ-018 SHALL NOT flush the branch itself or any older slot; only the issue input is squashed.
REQ-019 SHALL hold fwd_sel at 0 when a bubble enters slot0.
REQ-020 SHALL compute inflight_cnt as the population count of slot valid bits after the edge.

Reset
REQ-021 SHALL, while rst_n=0, immediately clear all slots, the flush counter, fwd_sel_rs1/rs2 and inflight_cnt to 0; stall_o and flush_o read 0.
REQ-022 SHALL apply reset mid-flush or mid-stall as an abort: no pending flush or stall survives reset, and the first edge after release may accept an issue.

Verification (defaults DEPTH=3, LOAD_LAT=1, FLUSH_CYC=2)
REQ-023 SHALL be checked for ALU-to-ALU forwarding: issue add x5, then next cycle add x6,x5,x5 -> no stall; fwd_sel_rs1=fwd_sel_rs2=1 when the second instruction is in EX.
REQ-024 SHALL be checked for load-use: lw x7, then next cycle add x8,x7,x0 -> stall_o=1 for one cycle, inflight_cnt shows a bubble; on re-issue fwd_sel_rs1=2.
REQ-025 SHALL be checked for x0 and distance: write x0 then read x0 -> sel 0, no stall; producer 3 issues earlier -> sel 0.
REQ-026 SHALL be checked for branch flush: br_taken=1 with a valid slot0 -> flush_o high 2 cycles; the 2 presented issues are squashed (slot0 bubbles); a 3rd issue is accepted.
REQ-027 SHALL be checked for simultaneous events: a load-use hazard and br_taken in the same cycle -> flush_o=1, stall_o=0; also br_taken with slot0 a bubble -> ignored.
REQ-028 SHALL be checked for reset mid-operation: rst_n low during a flush count -> all outputs 0 at once; after release, issue accepted on the first edge with inflight_cnt=1.
